// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-select encoding, rate lookup and frame constants.
package uart_pkg;

  localparam int unsigned BAUD_SEL_W    = 3;
  localparam int unsigned OVERSAMPLE    = 16;
  localparam int unsigned DATA_PARITY_W = 9;

  localparam logic [BAUD_SEL_W-1:0] BAUD_2400   = 3'd0;
  localparam logic [BAUD_SEL_W-1:0] BAUD_4800   = 3'd1;
  localparam logic [BAUD_SEL_W-1:0] BAUD_9600   = 3'd2;
  localparam logic [BAUD_SEL_W-1:0] BAUD_19200  = 3'd3;
  localparam logic [BAUD_SEL_W-1:0] BAUD_38400  = 3'd4;
  localparam logic [BAUD_SEL_W-1:0] BAUD_57600  = 3'd5;
  localparam logic [BAUD_SEL_W-1:0] BAUD_115200 = 3'd6;
  localparam logic [BAUD_SEL_W-1:0] BAUD_RSVD   = 3'd7;

  localparam logic [BAUD_SEL_W-1:0] BAUD_DEFAULT = BAUD_9600;

  // Bit rate in bit/s for a select code; the reserved code maps to 9600.
  function automatic int unsigned rate(input logic [BAUD_SEL_W-1:0] sel);
    int unsigned r;
    case (sel)
      BAUD_2400:   r = 32'd2400;
      BAUD_4800:   r = 32'd4800;
      BAUD_9600:   r = 32'd9600;
      BAUD_19200:  r = 32'd19200;
      BAUD_38400:  r = 32'd38400;
      BAUD_57600:  r = 32'd57600;
      BAUD_115200: r = 32'd115200;
      default:     r = 32'd9600;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/baud_tick_divider.sv
// Divides the oversampling tick by OVERSAMPLE to produce a registered 1x bit tick.
module baud_tick_divider
  import uart_pkg::*;
#(
  parameter int unsigned DIV = OVERSAMPLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic bit_tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             bit_tick_d;

  // Next count and bit tick; the pulse coincides with the tick that wraps the count.
  always_comb begin
    cnt_d      = cnt;
    bit_tick_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt == CNT_LAST) begin
        cnt_d      = '0;
        bit_tick_d = 1'b1;
      end else begin
        cnt_d = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      bit_tick <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      bit_tick <= bit_tick_d;
    end
  end

endmodule

// File: rtl/baud_rate_generator.sv
// Phase-accumulator baud generator: 16x square wave, its rising-edge tick and a 1x bit tick.
module baud_rate_generator
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [BAUD_SEL_W-1:0] baudSelect,
  output logic                  baudRateOut,
  output logic                  baudTick,
  output logic                  bitTick
);

  localparam logic [ACC_W-1:0] CLK_LIMIT = ACC_W'(CLK_FREQ);

  // Elaboration checks: accumulator must hold 2*CLK_FREQ and every increment must stay below CLK_FREQ.
  if ($clog2(64'(CLK_FREQ) * 64'd2 + 64'd1) > ACC_W) begin : g_acc_too_narrow
    $fatal(1, "ACC_W too narrow to hold 2*CLK_FREQ");
  end

  for (genvar i = 0; i < (1 << BAUD_SEL_W); i++) begin : g_inc_check
    if (64'(2) * 64'(OVERSAMPLE) * 64'(rate(BAUD_SEL_W'(i))) >= 64'(CLK_FREQ)) begin : g_bad
      $fatal(1, "baud increment not below CLK_FREQ");
    end
  end

  function automatic logic [ACC_W-1:0] inc_of(input logic [BAUD_SEL_W-1:0] sel);
    return ACC_W'(64'(2) * 64'(OVERSAMPLE) * 64'(rate(sel)));
  endfunction

  logic [BAUD_SEL_W-1:0] active_sel;
  logic [BAUD_SEL_W-1:0] sel_d;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      acc_d;
  logic [ACC_W-1:0]      inc_active;
  logic [ACC_W-1:0]      inc_new;
  logic [ACC_W-1:0]      sum;
  logic                  wrap;
  logic                  sel_change;
  logic                  out_d;
  logic                  tick_c;
  logic                  clear_c;

  assign inc_active = inc_of(active_sel);
  assign inc_new    = inc_of(baudSelect);
  assign sum        = acc + inc_active;
  assign wrap       = (sum >= CLK_LIMIT);
  assign sel_change = (baudSelect != active_sel);

  // The select-latch cycle counts as the first running cycle of the new rate.
  always_comb begin
    sel_d   = active_sel;
    acc_d   = acc;
    out_d   = baudRateOut;
    tick_c  = 1'b0;
    clear_c = 1'b0;
    if (sel_change) begin
      sel_d = baudSelect;
    end
    if (!enable) begin
      acc_d   = '0;
      out_d   = 1'b0;
      clear_c = 1'b1;
    end else if (sel_change) begin
      acc_d   = inc_new;
      out_d   = 1'b0;
      clear_c = 1'b1;
    end else if (wrap) begin
      acc_d  = sum - CLK_LIMIT;
      out_d  = ~baudRateOut;
      tick_c = ~baudRateOut;
    end else begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_sel  <= BAUD_DEFAULT;
      acc         <= '0;
      baudRateOut <= 1'b0;
      baudTick    <= 1'b0;
    end else begin
      active_sel  <= sel_d;
      acc         <= acc_d;
      baudRateOut <= out_d;
      baudTick    <= tick_c;
    end
  end

  baud_tick_divider #(
    .DIV (OVERSAMPLE)
  ) u_tick_divider (
    .clk      (clk),
    .rst_n    (rst),
    .clear    (clear_c),
    .tick     (tick_c),
    .bit_tick (bitTick)
  );

endmodule

// File: tb/tb_baud_rate_generator.sv
// Directed self-checking bench for baud_rate_generator at 50 MHz.
module tb_baud_rate_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] baudSelect;
  logic       baudRateOut;
  logic       baudTick;
  logic       bitTick;

  int checks = 0;
  int passed = 0;

  always #10 clk = ~clk;

  baud_rate_generator dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .baudSelect  (baudSelect),
    .baudRateOut (baudRateOut),
    .baudTick    (baudTick),
    .bitTick     (bitTick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Disable for two clocks with the new select, then re-enable; the next edge is running cycle 1.
  task automatic restart(input logic [2:0] sel);
    enable     = 1'b0;
    baudSelect = sel;
    step();
    step();
    enable = 1'b1;
  endtask

  task automatic test_reset();
    int first;
    rst        = 1'b0;
    enable     = 1'b1;
    baudSelect = 3'd0;
    #45;
    checks++; if (baudRateOut !== 1'b0) $display("FAIL reset_out: got %b expected 0", baudRateOut); else passed++;
    checks++; if (baudTick !== 1'b0) $display("FAIL reset_tick: got %b expected 0", baudTick); else passed++;
    checks++; if (bitTick !== 1'b0) $display("FAIL reset_bit: got %b expected 0", bitTick); else passed++;
    #160;
    rst   = 1'b1;
    first = -1;
    for (int n = 1; n <= 1000; n++) begin
      step();
      if (baudRateOut === 1'b1) begin
        first = n;
        break;
      end
    end
    checks++; if (first != 652) $display("FAIL reset_first_rise: got %0d expected 652", first); else passed++;
    checks++; if (baudTick !== 1'b1) $display("FAIL reset_first_tick: got %b expected 1", baudTick); else passed++;
    checks++; if (bitTick !== 1'b0) $display("FAIL reset_first_bit: got %b expected 0", bitTick); else passed++;
  endtask

  task automatic test_rate(input logic [2:0] sel, input int exp_rises, input int exp_first,
                           input int lo, input int hi);
    int   rises, first, bad_half, last_toggle, bits;
    logic prev_out;
    restart(sel);
    rises = 0; first = -1; bad_half = 0; last_toggle = 0; bits = 0;
    prev_out = 1'b0;
    for (int n = 1; n <= 15625; n++) begin
      step();
      if (baudTick === 1'b1) begin
        rises++;
        if (first < 0) first = n;
      end
      if (bitTick === 1'b1) bits++;
      if (baudRateOut !== prev_out) begin
        if (last_toggle != 0 && (n - last_toggle < lo || n - last_toggle > hi)) bad_half++;
        last_toggle = n;
        prev_out    = baudRateOut;
      end
    end
    checks++; if (rises != exp_rises) $display("FAIL rate_rises sel=%0d: got %0d expected %0d", sel, rises, exp_rises); else passed++;
    checks++; if (first != exp_first) $display("FAIL rate_first sel=%0d: got %0d expected %0d", sel, first, exp_first); else passed++;
    checks++; if (bad_half != 0) $display("FAIL rate_half_period sel=%0d: got %0d bad expected 0", sel, bad_half); else passed++;
    checks++; if (bits != exp_rises / 16) $display("FAIL rate_bit_ticks sel=%0d: got %0d expected %0d", sel, bits, exp_rises / 16); else passed++;
  endtask

  task automatic test_bit_tick();
    int   ticks, bits, bad;
    logic prev_bit;
    restart(3'd6);
    ticks = 0; bits = 0; bad = 0; prev_bit = 1'b0;
    for (int n = 1; n <= 3000 && ticks < 64; n++) begin
      step();
      if (baudTick === 1'b1) ticks++;
      if (bitTick === 1'b1) begin
        bits++;
        if (baudTick !== 1'b1 || (ticks % 16) != 0 || prev_bit === 1'b1) bad++;
      end
      prev_bit = bitTick;
    end
    checks++; if (ticks != 64) $display("FAIL bit_tick_budget: got %0d ticks expected 64", ticks); else passed++;
    checks++; if (bits != 4) $display("FAIL bit_tick_count: got %0d expected 4", bits); else passed++;
    checks++; if (bad != 0) $display("FAIL bit_tick_align: got %0d bad expected 0", bad); else passed++;
    step();
    checks++; if (bitTick !== 1'b0) $display("FAIL bit_tick_width: got %b expected 0", bitTick); else passed++;
  endtask

  task automatic test_select_change();
    int first, high_len, guard;
    restart(3'd0);
    guard = 0;
    while (baudRateOut !== 1'b1 && guard < 700) begin
      step();
      guard++;
    end
    checks++; if (guard != 652) $display("FAIL sel_pre_rise: got %0d expected 652", guard); else passed++;
    baudSelect = 3'd6;
    first = -1;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (n == 1) begin
        checks++; if (baudRateOut !== 1'b0 || baudTick !== 1'b0)
          $display("FAIL sel_force_low: got out=%b tick=%b expected 0 0", baudRateOut, baudTick); else passed++;
      end
      if (baudRateOut === 1'b1) begin
        first = n;
        break;
      end
    end
    checks++; if (first != 14) $display("FAIL sel_first_rise: got %0d expected 14", first); else passed++;
    high_len = 0;
    while (baudRateOut === 1'b1 && high_len < 100) begin
      high_len++;
      step();
    end
    checks++; if (high_len < 13 || high_len > 14) $display("FAIL sel_high_len: got %0d expected 13..14", high_len); else passed++;
  endtask

  task automatic test_enable_toggle();
    int ticks, guard, viol, first, tick_idx, bit_at;
    restart(3'd2);
    ticks = 0; guard = 0;
    while (ticks < 3 && guard < 2000) begin
      step();
      guard++;
      if (baudTick === 1'b1) ticks++;
    end
    checks++; if (ticks != 3) $display("FAIL en_warmup: got %0d ticks expected 3", ticks); else passed++;
    enable = 1'b0;
    viol   = 0;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (baudRateOut !== 1'b0 || baudTick !== 1'b0 || bitTick !== 1'b0) viol++;
    end
    checks++; if (viol != 0) $display("FAIL en_idle: got %0d active cycles expected 0", viol); else passed++;
    enable   = 1'b1;
    first    = -1;
    tick_idx = 0;
    bit_at   = -1;
    for (int n = 1; n <= 7000; n++) begin
      step();
      if (baudTick === 1'b1) begin
        tick_idx++;
        if (first < 0) first = n;
      end
      if (bitTick === 1'b1) begin
        bit_at = tick_idx;
        break;
      end
    end
    checks++; if (first != 163) $display("FAIL en_first_rise: got %0d expected 163", first); else passed++;
    checks++; if (bit_at != 16) $display("FAIL en_counter_restart: got bit tick at tick %0d expected 16", bit_at); else passed++;
  endtask

  task automatic test_async_reset();
    int guard, rise1, rise2, rises;
    guard = 0;
    while (baudRateOut !== 1'b1 && guard < 400) begin
      step();
      guard++;
    end
    checks++; if (baudRateOut !== 1'b1) $display("FAIL arst_pre_high: got %b expected 1", baudRateOut); else passed++;
    #4;
    rst = 1'b0;
    #1;
    checks++; if (baudRateOut !== 1'b0 || baudTick !== 1'b0 || bitTick !== 1'b0)
      $display("FAIL arst_immediate: got out=%b tick=%b bit=%b expected 0 0 0", baudRateOut, baudTick, bitTick); else passed++;
    baudSelect = 3'd7;
    enable     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b1;
    rise1 = -1; rise2 = -1; rises = 0;
    for (int n = 1; n <= 600; n++) begin
      step();
      if (baudTick === 1'b1) begin
        rises++;
        if (rises == 1) rise1 = n;
        if (rises == 2) begin
          rise2 = n;
          break;
        end
      end
    end
    checks++; if (rise1 != 163) $display("FAIL arst_sel7_rise1: got %0d expected 163", rise1); else passed++;
    checks++; if (rise2 != 489) $display("FAIL arst_sel7_rise2: got %0d expected 489", rise2); else passed++;
  endtask

  initial begin
    test_reset();
    test_rate(3'd0, 12, 652, 651, 652);
    test_rate(3'd2, 48, 163, 162, 163);
    test_rate(3'd6, 576, 14, 13, 14);
    test_bit_tick();
    test_select_change();
    test_enable_toggle();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
